// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM capture block.
// Holds the capture FSM state enum, duty width and default counter width.
package pwm_pkg;

   localparam int DUTY_W        = 8;
   localparam int CNT_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      WAIT_RISE,
      HIGH,
      LOW
   } cap_state_t;

endpackage

// File: rtl/pwm_div.sv
// pwm_div: restoring divider, one quotient bit per clk, DUTY_W cycles.
// Ports: start/dividend/divisor in; busy, done, quotient out.
// done and quotient are valid together during the final iteration cycle.
// The dividend must be below the divisor so the quotient fits DUTY_W bits.
module pwm_div
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  dividend,
   input  logic [CNT_W-1:0]  divisor,
   output logic              busy,
   output logic              done,
   output logic [DUTY_W-1:0] quotient
);

   logic [CNT_W:0]    rem;
   logic [CNT_W-1:0]  dsr;
   logic [DUTY_W-1:0] q;
   logic [2:0]        iter;
   logic [CNT_W:0]    sh;
   logic [CNT_W:0]    diff;
   logic              qbit;

   always_comb begin
      sh       = rem << 1;
      diff     = sh - {1'b0, dsr};
      qbit     = (sh >= {1'b0, dsr});
      quotient = {q[DUTY_W-2:0], qbit};
      done     = busy && (iter == 3'd7);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem  <= '0;
         dsr  <= '0;
         q    <= '0;
         iter <= '0;
         busy <= 1'b0;
      end else if (start && !busy) begin
         rem  <= {1'b0, dividend};
         dsr  <= divisor;
         q    <= '0;
         iter <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         rem  <= qbit ? diff : sh;
         q    <= quotient;
         iter <= iter + 3'd1;
         if (done)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and duty of an async PWM input.
// Ports: clk, rst_n, pwm_in in; high_len, period_len, duty, valid,
// stuck_high, stuck_low, overrun out. TIMEOUT must be below 2^CNT_W-1.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pwm_in,
   output logic [CNT_W-1:0]  high_len,
   output logic [CNT_W-1:0]  period_len,
   output logic [DUTY_W-1:0] duty,
   output logic              valid,
   output logic              stuck_high,
   output logic              stuck_low,
   output logic              overrun
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   cap_state_t state, state_n;

   logic             s1, s2, s3;
   logic [2:0]       fill;
   logic             rise, fall;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
   logic [CNT_W-1:0] hi_lat, hi_n;
   logic [CNT_W-1:0] pend_hi, pend_per;
   logic             to_done, to_done_n;
   logic             at_to;
   logic             start, drop, to_hi, to_lo;
   logic             busy, done;
   logic [DUTY_W-1:0] quo;

   // fill keeps reset zeros in the synchronizer from looking like an edge,
   // so a pin already high at release is not taken as a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         fill <= '0;
      end else begin
         s1   <= pwm_in;
         s2   <= s1;
         s3   <= s2;
         fill <= {fill[1:0], 1'b1};
      end
   end

   assign rise    = fill[2] & s2 & ~s3;
   assign fall    = fill[2] & ~s2 & s3;
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + ONE;
   assign at_to   = (cnt >= TO_C);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt_inc;
      hi_n      = hi_lat;
      to_done_n = to_done;
      start     = 1'b0;
      drop      = 1'b0;
      to_hi     = 1'b0;
      to_lo     = 1'b0;
      unique case (state)
         WAIT_RISE: begin
            if (rise) begin
               state_n   = HIGH;
               cnt_n     = ONE;
               to_done_n = 1'b0;
            end else if (fall) begin
               cnt_n     = '0;
               to_done_n = 1'b0;
            end else if (!to_done && at_to) begin
               to_lo     = 1'b1;
               to_done_n = 1'b1;
            end
         end
         HIGH: begin
            if (fall) begin
               state_n = LOW;
               hi_n    = cnt;
            end else if (at_to) begin
               to_hi     = 1'b1;
               to_done_n = 1'b1;
               state_n   = WAIT_RISE;
            end
         end
         LOW: begin
            if (rise) begin
               state_n = HIGH;
               cnt_n   = ONE;
               drop    = busy;
               start   = !busy;
            end else if (at_to) begin
               to_lo     = 1'b1;
               to_done_n = 1'b1;
               state_n   = WAIT_RISE;
            end
         end
         default: state_n = WAIT_RISE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_RISE;
         cnt      <= '0;
         hi_lat   <= '0;
         to_done  <= 1'b0;
         pend_hi  <= '0;
         pend_per <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         hi_lat  <= hi_n;
         to_done <= to_done_n;
         if (start) begin
            pend_hi  <= hi_lat;
            pend_per <= cnt;
         end
      end
   end

   pwm_div #(
      .CNT_W (CNT_W)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .dividend (hi_lat),
      .divisor  (cnt),
      .busy     (busy),
      .done     (done),
      .quotient (quo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_len   <= '0;
         period_len <= '0;
         duty       <= '0;
         valid      <= 1'b0;
         stuck_high <= 1'b0;
         stuck_low  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         valid   <= 1'b0;
         overrun <= drop;
         if (to_hi) begin
            high_len   <= '0;
            period_len <= '0;
            duty       <= '1;
            valid      <= 1'b1;
            stuck_high <= 1'b1;
            stuck_low  <= 1'b0;
         end else if (to_lo) begin
            high_len   <= '0;
            period_len <= '0;
            duty       <= '0;
            valid      <= 1'b1;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b1;
         end else if (done) begin
            high_len   <= pend_hi;
            period_len <= pend_per;
            duty       <= quo;
            valid      <= 1'b1;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
         end
      end
   end

endmodule
